decimal_entry: RTL and testbench
================================

# decimal_entry

Decimal keypad entry block: accepts decoded key codes one at a time, builds a 3-digit decimal number, and on Enter converts it to an 8-bit binary port value with a multi-cycle multiply-by-10 accumulator. It is the input-side counterpart of the binary-to-BCD display path. Its committed value feeds a CPU input port. Its live BCD digits can be routed straight to the VGA digit display as entry feedback.

## Interface
Parameters:
- MAX_DIGITS, 3, number of decimal digits held; fixed at 3 for 8-bit output.
- WIDTH, 8, output value width; results above 2^WIDTH-1 are errors.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- key_valid  in  1  key_code is valid this cycle.
- key_code  in  4  0x0-0x9 = digit, 0xA = backspace, 0xB = clear, 0xC = enter; 0xD-0xF are ignored.
- key_ready  out  1  block accepts a key this cycle.
- value  out  WIDTH  last committed binary value.
- value_valid  out  1  one-cycle pulse when value updates.
- err  out  1  last Enter produced a result greater than 255.
- dig_h, dig_t, dig_o  out  4 each  live BCD entry digits: hundreds, tens, ones.
- count  out  2  number of digits entered, 0-3.

## Operation
- Reset values:
  - state ENTRY
  - key_ready 1
  - value 0, value_valid 0, err 0
  - all digits 0, count 0
  - internal accumulator 0
- A key is accepted only on a cycle with key_valid && key_ready. Keys presented while key_ready=0 are dropped; there is no buffering.
- Any accepted key clears err, including an ignored code.
- ENTRY state:
  - Digit, count<3: dig_h<=dig_t, dig_t<=dig_o, dig_o<=key, count+1.
  - Digit, count=3: ignored; digits and count unchanged.
  - Backspace, count>0: dig_o<=dig_t, dig_t<=dig_h, dig_h<=0, count-1.
  - Backspace, count=0: no effect.
  - Clear: all digits 0, count 0. value is unchanged.
  - Enter, count>0: acc<=0, go to CONV, key_ready<=0.
  - Enter, count=0: ignored.
  - Codes 0xD-0xF: ignored.
- CONV state: lasts 3 cycles, one digit per cycle in order h, t, o.
  - acc <= acc*10 + digit, using a 10-bit accumulator (max 999). No truncation inside the accumulator.
  - Digits hold their values during CONV.
  - After the ones digit, go to DONE.
- DONE state: lasts 1 cycle.
  - If acc <= 255: value <= acc[7:0], value_valid <= 1 for one cycle.
  - Else: err <= 1, value unchanged, no value_valid.
  - Either way: digits cleared, count 0, return to ENTRY, key_ready <= 1.
- Leading zeros are handled naturally, because shifted-in digits always start from 0.
- value_valid is deasserted on every cycle other than the one following DONE.

## Timing
- All outputs are registered.
- An accepted digit, backspace or clear key at edge t is visible on the digit outputs and count in cycle t+1.
- Enter accepted at edge t:
  - key_ready is low in cycles t+1 through t+4. CONV occupies cycles t+1, t+2, t+3; DONE is cycle t+4.
  - value, value_valid and err are visible in cycle t+5; key_ready returns high in cycle t+5.
  - Enter-to-result latency is 5 cycles. Throughput is one Enter per 5 cycles.
- Reset asserted in any state, including mid-CONV, returns every output to its reset value on the next edge. No value_valid is emitted for an interrupted conversion.
- key_valid held high across cycles is treated as a new key on every cycle that key_ready is high. Upstream must pulse key_valid once per keypress.

## Test plan
- Reset, then keys 1,2,8,Enter -> dig_h/dig_t/dig_o show 1,2,8; key_ready low for 4 cycles; value=128 with a single value_valid pulse 5 cycles after Enter; digits and count return to 0.
- Keys 2,5,5,Enter then 2,5,6,Enter -> first Enter gives value=255 with value_valid; second gives err=1, value stays 255, no pulse; the next digit key clears err.
- Keys 4,Enter and 0,0,7,Enter -> value=4, then value=7. Enter with count=0 -> no state change, no pulse.
- Keys 9,8,7,6 -> fourth digit ignored, digits 9,8,7; then Backspace -> digits 0,9,8, count=2; then Clear -> all digits 0, value unchanged.
- Enter, then key_valid with digit 5 in cycle t+2 -> key dropped; digits after DONE are 0,0,0.
- Enter, then rst asserted in cycle t+2 -> next cycle all outputs at reset values; value_valid never pulses.

Source files
------------

// File: rtl/decimal_entry.sv
// Decimal keypad entry: collects up to three BCD digits, then converts them to
// binary on Enter with a three-cycle multiply-by-10 accumulator.
module decimal_entry #(
  parameter int MAX_DIGITS = 3,
  parameter int WIDTH      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic             key_ready,
  output logic [WIDTH-1:0] value,
  output logic             value_valid,
  output logic             err,
  output logic [3:0]       dig_h,
  output logic [3:0]       dig_t,
  output logic [3:0]       dig_o,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {ENTRY, CONV, DONE} state_t;

  localparam logic [1:0] MAX_COUNT = 2'(MAX_DIGITS);
  localparam logic [9:0] MAX_VAL   = 10'((1 << WIDTH) - 1);

  localparam logic [3:0] KEY_BACK  = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;
  localparam logic [3:0] KEY_ENTER = 4'hC;

  state_t     state;
  logic [1:0] phase;
  logic [9:0] acc;
  logic [3:0] conv_digit;
  logic [9:0] acc_next;
  logic       accept;

  assign accept = key_valid && key_ready;

  // Conversion walks the digits most-significant first: h, t, o.
  always_comb begin
    conv_digit = dig_o;
    case (phase)
      2'd0:    conv_digit = dig_h;
      2'd1:    conv_digit = dig_t;
      default: conv_digit = dig_o;
    endcase
  end

  // acc*10 = acc*8 + acc*2; acc never exceeds 99 here, so 10 bits suffice.
  assign acc_next = (acc << 3) + (acc << 1) + {6'd0, conv_digit};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ENTRY;
      phase       <= 2'd0;
      acc         <= 10'd0;
      key_ready   <= 1'b1;
      value       <= '0;
      value_valid <= 1'b0;
      err         <= 1'b0;
      dig_h       <= 4'd0;
      dig_t       <= 4'd0;
      dig_o       <= 4'd0;
      count       <= 2'd0;
    end else begin
      value_valid <= 1'b0;
      case (state)
        ENTRY: begin
          if (accept) begin
            err <= 1'b0;
            if (key_code <= 4'd9) begin
              if (count < MAX_COUNT) begin
                dig_h <= dig_t;
                dig_t <= dig_o;
                dig_o <= key_code;
                count <= count + 2'd1;
              end
            end else if (key_code == KEY_BACK) begin
              if (count != 2'd0) begin
                dig_o <= dig_t;
                dig_t <= dig_h;
                dig_h <= 4'd0;
                count <= count - 2'd1;
              end
            end else if (key_code == KEY_CLEAR) begin
              dig_h <= 4'd0;
              dig_t <= 4'd0;
              dig_o <= 4'd0;
              count <= 2'd0;
            end else if (key_code == KEY_ENTER) begin
              if (count != 2'd0) begin
                acc       <= 10'd0;
                phase     <= 2'd0;
                key_ready <= 1'b0;
                state     <= CONV;
              end
            end
          end
        end
        CONV: begin
          acc   <= acc_next;
          phase <= phase + 2'd1;
          if (phase == 2'd2) state <= DONE;
        end
        DONE: begin
          if (acc <= MAX_VAL) begin
            value       <= acc[WIDTH-1:0];
            value_valid <= 1'b1;
          end else begin
            err <= 1'b1;
          end
          dig_h     <= 4'd0;
          dig_t     <= 4'd0;
          dig_o     <= 4'd0;
          count     <= 2'd0;
          key_ready <= 1'b1;
          state     <= ENTRY;
        end
        default: state <= ENTRY;
      endcase
    end
  end

endmodule

// File: tb/tb_decimal_entry.sv
// Directed bench for decimal_entry: key entry, editing, conversion timing,
// overflow error, dropped keys and reset during conversion.
module tb_decimal_entry;

  logic       clk;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic [7:0] value;
  logic       value_valid;
  logic       err;
  logic [3:0] dig_h;
  logic [3:0] dig_t;
  logic [3:0] dig_o;
  logic [1:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  decimal_entry #(.MAX_DIGITS(3), .WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_ready(key_ready),
    .value(value),
    .value_valid(value_valid),
    .err(err),
    .dig_h(dig_h),
    .dig_t(dig_t),
    .dig_o(dig_o),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one key for a single rising edge; returns on the following
  // falling edge, where the effect of the key is visible.
  task automatic press(input logic [3:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    key_valid = 1'b0;
    key_code = 4'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (key_ready !== 1'b1) begin n_fail++; $display("FAIL reset_key_ready: got %0b expected 1", key_ready); end
    n_checks++;
    if (value !== 8'd0 || value_valid !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL reset_value: got value=%0d vv=%0b err=%0b expected 0/0/0", value, value_valid, err);
    end
    n_checks++;
    if ({dig_h, dig_t, dig_o} !== 12'h000 || count !== 2'd0) begin
      n_fail++; $display("FAIL reset_digits: got %0h%0h%0h count=%0d expected 000 count=0", dig_h, dig_t, dig_o, count);
    end
  endtask

  task automatic test_basic();
    press(4'd1); press(4'd2); press(4'd8);
    n_checks++;
    if ({dig_h, dig_t, dig_o} !== 12'h128 || count !== 2'd3) begin
      n_fail++; $display("FAIL basic_digits: got %0h%0h%0h count=%0d expected 128 count=3", dig_h, dig_t, dig_o, count);
    end
    press(4'hC);
    for (int i = 1; i <= 4; i++) begin
      n_checks++;
      if (key_ready !== 1'b0 || value_valid !== 1'b0) begin
        n_fail++; $display("FAIL basic_busy_t%0d: got ready=%0b vv=%0b expected 0/0", i, key_ready, value_valid);
      end
      if (i == 1) begin
        n_checks++;
        if ({dig_h, dig_t, dig_o} !== 12'h128) begin
          n_fail++; $display("FAIL basic_conv_hold: got %0h%0h%0h expected 128", dig_h, dig_t, dig_o);
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (value !== 8'd128 || value_valid !== 1'b1 || err !== 1'b0 || key_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_result: got value=%0d vv=%0b err=%0b ready=%0b expected 128/1/0/1", value, value_valid, err, key_ready);
    end
    n_checks++;
    if ({dig_h, dig_t, dig_o} !== 12'h000 || count !== 2'd0) begin
      n_fail++; $display("FAIL basic_cleared: got %0h%0h%0h count=%0d expected 000 count=0", dig_h, dig_t, dig_o, count);
    end
    @(negedge clk);
    n_checks++;
    if (value_valid !== 1'b0 || value !== 8'd128) begin
      n_fail++; $display("FAIL basic_pulse_end: got vv=%0b value=%0d expected 0/128", value_valid, value);
    end
  endtask

  task automatic test_overflow();
    press(4'd2); press(4'd5); press(4'd5); press(4'hC);
    repeat (4) @(negedge clk);
    n_checks++;
    if (value !== 8'd255 || value_valid !== 1'b1 || err !== 1'b0) begin
      n_fail++; $display("FAIL ovf_255: got value=%0d vv=%0b err=%0b expected 255/1/0", value, value_valid, err);
    end
    press(4'd2); press(4'd5); press(4'd6); press(4'hC);
    for (int i = 1; i <= 4; i++) begin
      n_checks++;
      if (value_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_no_pulse_t%0d: got vv=%0b expected 0", i, value_valid); end
      @(negedge clk);
    end
    n_checks++;
    if (value !== 8'd255 || value_valid !== 1'b0 || err !== 1'b1 || key_ready !== 1'b1) begin
      n_fail++; $display("FAIL ovf_256: got value=%0d vv=%0b err=%0b ready=%0b expected 255/0/1/1", value, value_valid, err, key_ready);
    end
    n_checks++;
    if (count !== 2'd0) begin n_fail++; $display("FAIL ovf_count: got %0d expected 0", count); end
    press(4'd3);
    n_checks++;
    if (err !== 1'b0 || count !== 2'd1 || dig_o !== 4'd3) begin
      n_fail++; $display("FAIL ovf_err_clear: got err=%0b count=%0d dig_o=%0d expected 0/1/3", err, count, dig_o);
    end
    press(4'hB);
  endtask

  task automatic test_leading_zero();
    press(4'd4); press(4'hC);
    repeat (4) @(negedge clk);
    n_checks++;
    if (value !== 8'd4 || value_valid !== 1'b1) begin
      n_fail++; $display("FAIL lz_4: got value=%0d vv=%0b expected 4/1", value, value_valid);
    end
    press(4'd0); press(4'd0); press(4'd7); press(4'hC);
    repeat (4) @(negedge clk);
    n_checks++;
    if (value !== 8'd7 || value_valid !== 1'b1) begin
      n_fail++; $display("FAIL lz_007: got value=%0d vv=%0b expected 7/1", value, value_valid);
    end
    press(4'hC);
    n_checks++;
    if (key_ready !== 1'b1 || count !== 2'd0) begin
      n_fail++; $display("FAIL empty_enter_ready: got ready=%0b count=%0d expected 1/0", key_ready, count);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (value_valid !== 1'b0 || value !== 8'd7) begin
        n_fail++; $display("FAIL empty_enter_c%0d: got vv=%0b value=%0d expected 0/7", i, value_valid, value);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_edit();
    press(4'hA);
    n_checks++;
    if (count !== 2'd0 || {dig_h, dig_t, dig_o} !== 12'h000) begin
      n_fail++; $display("FAIL back_empty: got %0h%0h%0h count=%0d expected 000 count=0", dig_h, dig_t, dig_o, count);
    end
    press(4'd9); press(4'd8); press(4'd7); press(4'd6);
    n_checks++;
    if ({dig_h, dig_t, dig_o} !== 12'h987 || count !== 2'd3) begin
      n_fail++; $display("FAIL edit_full: got %0h%0h%0h count=%0d expected 987 count=3", dig_h, dig_t, dig_o, count);
    end
    press(4'hE);
    n_checks++;
    if ({dig_h, dig_t, dig_o} !== 12'h987 || count !== 2'd3) begin
      n_fail++; $display("FAIL edit_ignored_code: got %0h%0h%0h count=%0d expected 987 count=3", dig_h, dig_t, dig_o, count);
    end
    press(4'hA);
    n_checks++;
    if ({dig_h, dig_t, dig_o} !== 12'h098 || count !== 2'd2) begin
      n_fail++; $display("FAIL edit_back: got %0h%0h%0h count=%0d expected 098 count=2", dig_h, dig_t, dig_o, count);
    end
    press(4'hB);
    n_checks++;
    if ({dig_h, dig_t, dig_o} !== 12'h000 || count !== 2'd0 || value !== 8'd7) begin
      n_fail++; $display("FAIL edit_clear: got %0h%0h%0h count=%0d value=%0d expected 000 count=0 value=7", dig_h, dig_t, dig_o, count, value);
    end
  endtask

  task automatic test_drop();
    press(4'd1); press(4'hC);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 4'd5;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (value !== 8'd1 || value_valid !== 1'b1) begin
      n_fail++; $display("FAIL drop_value: got value=%0d vv=%0b expected 1/1", value, value_valid);
    end
    n_checks++;
    if ({dig_h, dig_t, dig_o} !== 12'h000 || count !== 2'd0) begin
      n_fail++; $display("FAIL drop_digits: got %0h%0h%0h count=%0d expected 000 count=0", dig_h, dig_t, dig_o, count);
    end
  endtask

  task automatic test_reset_mid();
    press(4'd2); press(4'hC);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (key_ready !== 1'b1 || value !== 8'd0 || value_valid !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL midrst_outputs: got ready=%0b value=%0d vv=%0b err=%0b expected 1/0/0/0", key_ready, value, value_valid, err);
    end
    n_checks++;
    if ({dig_h, dig_t, dig_o} !== 12'h000 || count !== 2'd0) begin
      n_fail++; $display("FAIL midrst_digits: got %0h%0h%0h count=%0d expected 000 count=0", dig_h, dig_t, dig_o, count);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (value_valid !== 1'b0 || value !== 8'd0) begin
        n_fail++; $display("FAIL midrst_no_pulse_c%0d: got vv=%0b value=%0d expected 0/0", i, value_valid, value);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_leading_zero();
    test_edit();
    test_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
